pwm_ramp_ctrl: RTL

Sequencer that owns one pwm core. On a start request it acts as Wishbone master and writes the core's divider, period and control registers. It then drives the core's external duty-cycle port with a stepped ramp from the current duty to a target duty, with a programmable dwell between steps. It sits between the system control logic and the pwm slave.

---
 rtl/pwm_ramp_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Sequencer for one pwm core: configures it over Wishbone, then ramps its
// external duty-cycle input towards a target in fixed steps with a dwell.
module pwm_ramp_ctrl #(
  parameter logic [15:0] ADR_DIV    = 16'h0002,
  parameter logic [15:0] ADR_PERIOD = 16'h0004,
  parameter logic [15:0] ADR_CTRL   = 16'h0000,
  parameter logic [15:0] CTRL_VAL   = 16'h0007,
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_div,
  input  logic [15:0] i_period,
  input  logic [15:0] i_target,
  input  logic [15:0] i_step,
  input  logic [15:0] i_hold,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic [15:0] i_wb_data,
  input  logic        i_wb_ack,
  output logic [15:0] o_DC,
  output logic        o_valid_DC,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;

  typedef enum logic [3:0] {
    IDLE, W_DIV, GAP1, W_PER, GAP2, W_CTRL, RAMP, HOLD, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d, period_q, period_d, tgt_q, tgt_d;
  logic [DW-1:0] step_q, step_d, hold_q, hold_d, cur_q, cur_d;
  logic [DW-1:0] cnt_q, cnt_d, adr_q, adr_d, data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cyc_q, cyc_d, busy_q, busy_d, valid_q, valid_d;
  logic          done_q, done_d, err_q, err_d;

  logic [DW:0]   cur_x, tgt_x, step_x, ramp_nxt;
  logic [DW-1:0] ramp_cur;
  logic          in_run;
  logic          unused_rdata;

  assign unused_rdata = ^i_wb_data;

  // Next ramp value, computed one bit wider so cur+step cannot wrap.
  always_comb begin
    cur_x  = {1'b0, cur_q};
    tgt_x  = {1'b0, tgt_q};
    step_x = {1'b0, step_q};
    if (step_q == '0) begin
      ramp_nxt = tgt_x;
    end else if (cur_x < tgt_x) begin
      ramp_nxt = ((tgt_x - cur_x) <= step_x) ? tgt_x : (cur_x + step_x);
    end else if (cur_x > tgt_x) begin
      ramp_nxt = ((cur_x - tgt_x) <= step_x) ? tgt_x : (cur_x - step_x);
    end else begin
      ramp_nxt = tgt_x;
    end
    ramp_cur = DW'(ramp_nxt);
  end

  assign in_run = (state_q != IDLE) && (state_q != ERR);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    period_d = period_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    hold_d   = hold_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    cyc_d    = 1'b0;
    adr_d    = adr_q;
    data_d   = data_q;
    busy_d   = 1'b0;

    case (state_q)
      IDLE, ERR: begin
        if (i_start && !i_abort) begin
          div_d    = i_div;
          period_d = i_period;
          tgt_d    = (i_target < i_period) ? i_target : i_period;
          step_d   = i_step;
          hold_d   = i_hold;
          err_d    = 1'b0;
          state_d  = W_DIV;
        end
      end
      W_DIV, W_PER, W_CTRL: begin
        if (i_wb_ack) begin
          case (state_q)
            W_DIV:   state_d = GAP1;
            W_PER:   state_d = GAP2;
            default: state_d = RAMP;
          endcase
        end else if (tmo_q == TW'(WB_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP1: state_d = W_PER;
      GAP2: state_d = W_CTRL;
      RAMP: begin
        cur_d   = ramp_cur;
        valid_d = 1'b1;
        if (ramp_cur == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (hold_q == '0) begin
          state_d = RAMP;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == (hold_q - DW'(1))) state_d = RAMP;
        else                            cnt_d   = cnt_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over ack, timeout and ramp completion.
    if (in_run && i_abort) begin
      state_d = IDLE;
      cur_d   = '0;
      valid_d = 1'b1;
      done_d  = 1'b0;
      err_d   = err_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end

    case (state_d)
      W_DIV: begin
        cyc_d  = 1'b1;
        adr_d  = ADR_DIV;
        data_d = div_d;
      end
      W_PER: begin
        cyc_d  = 1'b1;
        adr_d  = ADR_PERIOD;
        data_d = period_d;
      end
      W_CTRL: begin
        cyc_d  = 1'b1;
        adr_d  = ADR_CTRL;
        data_d = CTRL_VAL;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE) && (state_d != ERR);
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      period_q <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      period_q <= period_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = cyc_q;
  assign o_wb_we    = cyc_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_data  = data_q;
  assign o_DC       = cur_q;
  assign o_valid_DC = valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule
